maze_update_scheduler: RTL and testbench

MAZE_UPDATE_SCHEDULER -- requirements
Module: maze_update_scheduler

---
 rtl/maze_pkg.sv | 37 +++
 rtl/maze_fifo.sv | 59 +++++
 rtl/maze_update_scheduler.sv | 127 ++++++++++++
 tb/tb_maze_update_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared maze constants: grid size, update-word field positions, tile bit meanings
// and the scheduler state encoding.
package maze_pkg;

    localparam int GRID_W = 5;
    localparam int GRID_H = 4;

    localparam int X_MSB = 15;
    localparam int X_LSB = 13;
    localparam int Y_MSB = 12;
    localparam int Y_LSB = 11;

    localparam int TILE_DONE     = 0;
    localparam int TILE_ROBOT    = 1;
    localparam int TILE_EXPLORED = 2;
    localparam int TILE_TOP      = 3;
    localparam int TILE_RIGHT    = 4;
    localparam int TILE_BOTTOM   = 5;
    localparam int TILE_LEFT     = 6;

    localparam logic [2:0]  X_LAST     = 3'(GRID_W - 1);
    localparam logic [1:0]  Y_LAST     = 2'(GRID_H - 1);
    // Bits [10:8] are reserved and always forced to zero on issued words.
    localparam logic [15:0] ISSUE_MASK = 16'hF8FF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RADIO = 2'd1,
        ST_CLEAR = 2'd2
    } sched_state_t;

    function automatic logic [15:0] make_word(input logic [2:0] x, input logic [1:0] y,
                                              input logic [7:0] tile);
        return {x, y, 3'b000, tile};
    endfunction

endpackage

// File: rtl/maze_fifo.sv
// Small power-of-two FIFO with first-word fall-through read; a push on a full
// FIFO is accepted only when a pop happens in the same cycle.
module maze_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/maze_update_scheduler.sv
// Merges radio tile updates and full-grid clear sweeps into one write stream,
// issuing words only while the display is blanked.
module maze_update_scheduler
    import maze_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] CLEAR_DATA = 8'h00
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] RADIO_DATA,
    input  logic        RADIO_VAL,
    input  logic        CLEAR_REQ,
    input  logic        BLANK,
    output logic [15:0] DATA_OUT,
    output logic        DATA_VAL_OUT,
    output logic        BUSY,
    output logic        OVERFLOW,
    output logic [7:0]  BAD_CNT
);

    sched_state_t r_state;
    logic [2:0]   r_clr_x;
    logic [1:0]   r_clr_y;
    logic [15:0]  r_data_out;
    logic         r_data_val;
    logic         r_overflow;
    logic [7:0]   r_bad_cnt;

    logic         w_x_valid;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    logic [15:0]  w_fifo_in;
    logic [15:0]  w_fifo_out;

    assign w_x_valid = (RADIO_DATA[X_MSB:X_LSB] <= X_LAST);
    assign w_push    = RADIO_VAL && w_x_valid;
    assign w_fifo_in = RADIO_DATA & ISSUE_MASK;
    // Popping is allowed from IDLE too, so a lone word reaches the output in two cycles.
    assign w_pop     = (r_state != ST_CLEAR) && !w_empty && BLANK && !CLEAR_REQ;

    maze_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk       (CLK),
        .rst       (RESET),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_wr_data (w_fifo_in),
        .o_rd_data (w_fifo_out),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= ST_IDLE;
            r_clr_x    <= '0;
            r_clr_y    <= '0;
            r_data_out <= '0;
            r_data_val <= 1'b0;
        end else begin
            r_data_val <= 1'b0;
            if (w_pop) begin
                r_data_out <= w_fifo_out;
                r_data_val <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (CLEAR_REQ) begin
                        r_state <= ST_CLEAR;
                    end else if (!w_empty) begin
                        r_state <= ST_RADIO;
                    end
                end
                ST_RADIO: begin
                    if (CLEAR_REQ) begin
                        r_state <= ST_CLEAR;
                    end else if (w_empty) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    if (BLANK) begin
                        r_data_out <= make_word(r_clr_x, r_clr_y, CLEAR_DATA);
                        r_data_val <= 1'b1;
                        if (r_clr_x == X_LAST && r_clr_y == Y_LAST) begin
                            r_state <= ST_IDLE;
                            r_clr_x <= '0;
                            r_clr_y <= '0;
                        end else if (r_clr_x == X_LAST) begin
                            r_clr_x <= '0;
                            r_clr_y <= r_clr_y + 1'b1;
                        end else begin
                            r_clr_x <= r_clr_x + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_overflow <= 1'b0;
            r_bad_cnt  <= '0;
        end else begin
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            if (RADIO_VAL && !w_x_valid && r_bad_cnt != 8'hFF) begin
                r_bad_cnt <= r_bad_cnt + 8'd1;
            end
        end
    end

    assign DATA_OUT     = r_data_out;
    assign DATA_VAL_OUT = r_data_val;
    assign BUSY         = (r_state == ST_CLEAR) || !w_empty;
    assign OVERFLOW     = r_overflow;
    assign BAD_CNT      = r_bad_cnt;

endmodule

// File: tb/tb_maze_update_scheduler.sv
// Directed bench for maze_update_scheduler: a queue/index model predicts every
// output each cycle, and literal expectations pin the key scenarios.
module tb_maze_update_scheduler;

    localparam logic [7:0] TB_CLEAR = 8'h00;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [15:0] RADIO_DATA = 16'h0000;
    logic        RADIO_VAL = 1'b0;
    logic        CLEAR_REQ = 1'b0;
    logic        BLANK = 1'b0;
    logic [15:0] DATA_OUT;
    logic        DATA_VAL_OUT;
    logic        BUSY;
    logic        OVERFLOW;
    logic [7:0]  BAD_CNT;

    maze_update_scheduler #(
        .FIFO_DEPTH (4),
        .CLEAR_DATA (TB_CLEAR)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .RADIO_DATA   (RADIO_DATA),
        .RADIO_VAL    (RADIO_VAL),
        .CLEAR_REQ    (CLEAR_REQ),
        .BLANK        (BLANK),
        .DATA_OUT     (DATA_OUT),
        .DATA_VAL_OUT (DATA_VAL_OUT),
        .BUSY         (BUSY),
        .OVERFLOW     (OVERFLOW),
        .BAD_CNT      (BAD_CNT)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Behavioural model: a word queue, a clear-sweep tile index and the flags.
    logic [15:0] mq[$];
    bit          m_clr = 1'b0;
    int          m_idx = 0;
    bit          m_val = 1'b0;
    logic [15:0] m_data = 16'h0000;
    bit          m_ovf = 1'b0;
    int          m_bad = 0;

    function automatic logic [15:0] clear_word(input int idx);
        int x;
        int y;
        x = idx % 5;
        y = idx / 5;
        return 16'(x * 8192 + y * 2048 + int'(TB_CLEAR));
    endfunction

    initial begin
        forever begin
            @(posedge CLK);
            if (RESET) begin
                mq.delete();
                m_clr = 1'b0;
                m_idx = 0;
                m_val = 1'b0;
                m_data = 16'h0000;
                m_ovf = 1'b0;
                m_bad = 0;
            end else begin
                m_val = 1'b0;
                if (m_clr) begin
                    if (BLANK) begin
                        m_data = clear_word(m_idx);
                        m_val = 1'b1;
                        m_idx++;
                        if (m_idx == 20) begin
                            m_clr = 1'b0;
                            m_idx = 0;
                        end
                    end
                end else if (CLEAR_REQ) begin
                    m_clr = 1'b1;
                    m_idx = 0;
                end else if (BLANK && mq.size() > 0) begin
                    m_data = mq.pop_front() & 16'hF8FF;
                    m_val = 1'b1;
                end
                if (RADIO_VAL) begin
                    if (RADIO_DATA[15:13] > 3'd4) begin
                        if (m_bad < 255) m_bad++;
                    end else if (mq.size() < 4) begin
                        mq.push_back(RADIO_DATA);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model plus a log of issued words.
    logic [15:0] log_w[$];
    int          log_t[$];
    int          cyc = 0;

    initial begin
        forever begin
            @(posedge CLK);
            #2;
            cyc++;
            chk("model_val",  32'(DATA_VAL_OUT), 32'(m_val));
            chk("model_data", 32'(DATA_OUT),     32'(m_data));
            chk("model_busy", 32'(BUSY),         32'(m_clr || (mq.size() != 0)));
            chk("model_ovf",  32'(OVERFLOW),     32'(m_ovf));
            chk("model_bad",  32'(BAD_CNT),      32'(m_bad));
            if (DATA_VAL_OUT) begin
                log_w.push_back(DATA_OUT);
                log_t.push_back(cyc);
            end
        end
    end

    task automatic step(input logic v, input logic [15:0] d, input logic c, input logic b);
        RADIO_VAL = v;
        RADIO_DATA = d;
        CLEAR_REQ = c;
        BLANK = b;
        @(negedge CLK);
    endtask

    logic [15:0] ovf_words [5] = '{16'h0001, 16'h2802, 16'h5003, 16'h7804, 16'h8005};

    initial begin
        int guard;
        repeat (3) @(negedge CLK);
        chk("rst_data", 32'(DATA_OUT), 32'h0);
        chk("rst_val",  32'(DATA_VAL_OUT), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_ovf",  32'(OVERFLOW), 32'h0);
        chk("rst_bad",  32'(BAD_CNT), 32'h0);
        RESET = 1'b0;
        step(1'b0, 16'h0, 1'b0, 1'b1);

        // Minimum latency: strobe two cycles after the radio strobe.
        step(1'b1, 16'h4812, 1'b0, 1'b1);
        chk("lat_early_val", 32'(DATA_VAL_OUT), 32'h0);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        chk("lat_val",  32'(DATA_VAL_OUT), 32'h1);
        chk("lat_data", 32'(DATA_OUT), 32'h4812);
        repeat (3) step(1'b0, 16'h0, 1'b0, 1'b1);

        // Invalid x: discarded and counted, count saturates.
        log_w.delete();
        log_t.delete();
        step(1'b1, 16'hA000, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        chk("bad_one", 32'(BAD_CNT), 32'd1);
        chk("bad_no_write", 32'(log_w.size()), 32'd0);
        for (int i = 0; i < 299; i++) step(1'b1, 16'hA000, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        chk("bad_sat", 32'(BAD_CNT), 32'd255);

        // Overflow with blanking low, then drain in push order.
        log_w.delete();
        log_t.delete();
        for (int i = 0; i < 5; i++) step(1'b1, ovf_words[i], 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("ovf_flag", 32'(OVERFLOW), 32'h1);
        chk("ovf_busy", 32'(BUSY), 32'h1);
        repeat (8) step(1'b0, 16'h0, 1'b0, 1'b1);
        chk("ovf_count", 32'(log_w.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (log_w.size() > i) chk("ovf_order", 32'(log_w[i]), 32'(ovf_words[i]));
        end
        chk("ovf_sticky", 32'(OVERFLOW), 32'h1);

        // Full clear sweep with blanking held high.
        log_w.delete();
        log_t.delete();
        step(1'b0, 16'h0, 1'b1, 1'b1);
        repeat (25) step(1'b0, 16'h0, 1'b0, 1'b1);
        chk("clr_count", 32'(log_w.size()), 32'd20);
        if (log_w.size() == 20) begin
            chk("clr_first", 32'(log_w[0]), 32'h0000);
            chk("clr_row1",  32'(log_w[5]), 32'h0800);
            chk("clr_last",  32'(log_w[19]), 32'h9800);
            chk("clr_consec", 32'(log_t[19] - log_t[0]), 32'd19);
        end
        chk("clr_busy_end", 32'(BUSY), 32'h0);

        // Clear over queued words, paused by blanking after the 7th write.
        log_w.delete();
        log_t.delete();
        step(1'b1, 16'h2F55, 1'b0, 1'b0);
        step(1'b1, 16'h6344, 1'b0, 1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0);
        guard = 0;
        while (log_w.size() < 7 && guard < 100) begin
            step(1'b0, 16'h0, 1'b0, 1'b1);
            guard++;
        end
        chk("pause_reach7", 32'(log_w.size()), 32'd7);
        repeat (10) step(1'b0, 16'h0, 1'b0, 1'b0);
        chk("pause_hold", 32'(log_w.size()), 32'd7);
        chk("pause_busy", 32'(BUSY), 32'h1);
        repeat (25) step(1'b0, 16'h0, 1'b0, 1'b1);
        chk("pause_total", 32'(log_w.size()), 32'd22);
        if (log_w.size() == 22) begin
            chk("pause_w6",  32'(log_w[6]), 32'h2800);
            chk("pause_w7",  32'(log_w[7]), 32'h4800);
            chk("pause_w19", 32'(log_w[19]), 32'h9800);
            chk("pause_q0",  32'(log_w[20]), 32'h2855);
            chk("pause_q1",  32'(log_w[21]), 32'h6044);
        end

        // Reset in the middle of a sweep abandons it.
        step(1'b0, 16'h0, 1'b1, 1'b1);
        repeat (5) step(1'b0, 16'h0, 1'b0, 1'b1);
        RESET = 1'b1;
        repeat (2) step(1'b0, 16'h0, 1'b0, 1'b1);
        chk("mrst_data", 32'(DATA_OUT), 32'h0);
        chk("mrst_val",  32'(DATA_VAL_OUT), 32'h0);
        chk("mrst_busy", 32'(BUSY), 32'h0);
        chk("mrst_ovf",  32'(OVERFLOW), 32'h0);
        chk("mrst_bad",  32'(BAD_CNT), 32'h0);
        RESET = 1'b0;
        log_w.delete();
        log_t.delete();
        repeat (30) step(1'b0, 16'h0, 1'b0, 1'b1);
        chk("mrst_quiet", 32'(log_w.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
